// File: rtl/sync_reset_pipeline_if.sv
// Valid/ready/data stream bundle used on both sides of sync_reset_pipeline.
//   valid : word offered by the master side
//   ready : slave side accepts the word this cycle
//   data  : the word, WIDTH bits
// master: drives valid/data, samples ready. slave: samples valid/data, drives ready.
interface sync_reset_pipeline_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sync_reset_pipeline.sv
// Elastic valid/ready register pipeline, STAGES deep, with a synchronous
// active-low reset and a synchronous soft flush.
// Ports:
//   clk         rising-edge clock
//   sync_rst_n  synchronous active-low reset
//   flush       synchronous soft clear, active high
//   in_if       producer side (slave modport): valid/data in, ready out
//   out_if      consumer side (master modport): valid/data out, ready in
//   occupancy   number of valid stages, registered
module sync_reset_pipeline #(
    parameter int WIDTH      = 16,
    parameter int STAGES     = 3,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                          clk,
    input  logic                          sync_rst_n,
    input  logic                          flush,
    sync_reset_pipeline_if.slave          in_if,
    sync_reset_pipeline_if.master         out_if,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic [STAGES-1:0] stage_ready;
    logic              in_fire;
    logic              out_fire;

    // Stage i can load when out_ready is high or some stage from i up to the
    // output is empty; this is the unrolled form of ready[i]=!valid[i]||ready[i+1]
    // and avoids a self-referencing vector.
    always_comb begin
        logic full_above;
        full_above  = 1'b1;
        stage_ready = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_above     = full_above && valid_q[i];
            stage_ready[i] = !full_above || out_if.ready;
        end
    end

    // Nothing is accepted while reset or flush is asserted.
    assign in_if.ready = sync_rst_n && !flush && stage_ready[0];
    assign in_fire     = in_if.valid && in_if.ready;
    assign out_fire    = valid_q[STAGES-1] && out_if.ready;
    assign occ_d       = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);

    always_ff @(posedge clk) begin
        if (!sync_rst_n || flush) begin
            valid_q <= '0;
            occ_q   <= '0;
            if (CLEAR_DATA) begin
                for (int i = 0; i < STAGES; i++) begin
                    data_q[i] <= '0;
                end
            end
        end else begin
            // Data only moves with a valid word, so the output register
            // keeps the last delivered word when a bubble passes through.
            if (stage_ready[0]) begin
                valid_q[0] <= in_if.valid;
                if (in_if.valid) begin
                    data_q[0] <= in_if.data;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (stage_ready[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
            occ_q <= occ_d;
        end
    end

    assign out_if.valid = valid_q[STAGES-1];
    assign out_if.data  = data_q[STAGES-1];
    assign occupancy    = occ_q;

endmodule

// File: tb/tb_sync_reset_pipeline.sv
// Bench for sync_reset_pipeline: two instances driven identically,
// one with CLEAR_DATA=1 (a_*) and one with CLEAR_DATA=0 (b_*), checked
// against a queue model where each word carries its age in cycles.
module tb_sync_reset_pipeline;

    localparam int WIDTH  = 16;
    localparam int STAGES = 3;
    localparam int OCC_W  = $clog2(STAGES + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             sync_rst_n;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_data;
    logic [OCC_W-1:0] a_occ;
    logic [OCC_W-1:0] b_occ;

    sync_reset_pipeline_if #(.WIDTH(WIDTH)) a_in ();
    sync_reset_pipeline_if #(.WIDTH(WIDTH)) a_out ();
    sync_reset_pipeline_if #(.WIDTH(WIDTH)) b_in ();
    sync_reset_pipeline_if #(.WIDTH(WIDTH)) b_out ();

    assign a_in.valid  = in_valid;
    assign a_in.data   = in_data;
    assign a_out.ready = out_ready;
    assign b_in.valid  = in_valid;
    assign b_in.data   = in_data;
    assign b_out.ready = out_ready;

    sync_reset_pipeline #(.WIDTH(WIDTH), .STAGES(STAGES), .CLEAR_DATA(1'b1)) dut_a (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .flush      (flush),
        .in_if      (a_in),
        .out_if     (a_out),
        .occupancy  (a_occ)
    );

    sync_reset_pipeline #(.WIDTH(WIDTH), .STAGES(STAGES), .CLEAR_DATA(1'b0)) dut_b (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .flush      (flush),
        .in_if      (b_in),
        .out_if     (b_out),
        .occupancy  (b_occ)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               age;
    } word_t;

    word_t            q[$];
    logic [WIDTH-1:0] emitted[$];
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    bit               last_b_known;
    bit               last_acc;
    int               occ_peak;
    int               errors = 0;
    int               checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge against the model,
    // then advance the model on the rising edge. Returns 1ns after the edge.
    task automatic cycle(input string tag);
        bit               ov;
        bit               ir;
        logic [WIDTH-1:0] od;
        @(negedge clk);
        // A word reaches the output once it has spent STAGES-1 edges inside;
        // the head word is never blocked before the last stage.
        ov = (q.size() > 0) && (q[0].age >= STAGES - 1);
        ir = sync_rst_n && !flush && ((q.size() < STAGES) || out_ready);
        if (ov) begin
            last_a       = q[0].data;
            last_b       = q[0].data;
            last_b_known = 1'b1;
        end
        od = last_a;
        check($sformatf("%s.a_out_valid", tag), 32'(a_out.valid), 32'(ov));
        check($sformatf("%s.a_in_ready", tag), 32'(a_in.ready), 32'(ir));
        check($sformatf("%s.a_occ", tag), 32'(a_occ), 32'(q.size()));
        check($sformatf("%s.a_out_data", tag), 32'(a_out.data), 32'(od));
        check($sformatf("%s.b_out_valid", tag), 32'(b_out.valid), 32'(ov));
        check($sformatf("%s.b_in_ready", tag), 32'(b_in.ready), 32'(ir));
        check($sformatf("%s.b_occ", tag), 32'(b_occ), 32'(q.size()));
        if (last_b_known) begin
            check($sformatf("%s.b_out_data", tag), 32'(b_out.data), 32'(last_b));
        end
        if (32'(a_occ) > occ_peak) occ_peak = int'(a_occ);
        last_acc = 1'b0;
        @(posedge clk);
        if (!sync_rst_n || flush) begin
            q.delete();
            last_a = '0;
        end else begin
            if (ov && out_ready) begin
                emitted.push_back(q[0].data);
                q.delete(0);
            end
            foreach (q[k]) q[k].age++;
            if (in_valid && ir) begin
                q.push_back('{data: in_data, age: 0});
                last_acc = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        int n;
        sync_rst_n   = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_data      = '0;
        last_a       = '0;
        last_b       = '0;
        last_b_known = 1'b0;
        occ_peak     = 0;

        // reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t1_rst_out_valid", 32'(a_out.valid), 32'd0);
        check("t1_rst_out_data", 32'(a_out.data), 32'h0000);
        check("t1_rst_occ", 32'(a_occ), 32'd0);
        check("t1_rst_in_ready", 32'(a_in.ready), 32'd0);
        sync_rst_n = 1'b1;
        #1;
        check("t1_rel_in_ready", 32'(a_in.ready), 32'd1);
        cycle("t1_idle");

        // streaming, unstalled
        out_ready = 1'b1;
        emitted.delete();
        occ_peak = 0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h1000 + 16'(k);
            cycle("t2_push");
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) cycle("t2_drain");
        check("t2_emit_count", 32'(emitted.size()), 32'd5);
        for (int k = 0; k < emitted.size(); k++) begin
            check("t2_emit_order", 32'(emitted[k]), 32'h1001 + 32'(k));
        end
        check("t2_occ_peak", 32'(occ_peak), 32'd3);

        // backpressure
        emitted.delete();
        out_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h2001 + 16'(n);
            cycle("t3_fill");
            if (last_acc) n++;
        end
        check("t3_accepted", 32'(n), 32'd3);
        check("t3_occ_full", 32'(a_occ), 32'd3);
        check("t3_in_ready_full", 32'(a_in.ready), 32'd0);
        check("t3_out_held", 32'(a_out.data), 32'h2001);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && n < 4; k++) begin
            in_data = 16'h2001 + 16'(n);
            cycle("t3_release");
            if (last_acc) n++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) cycle("t3_drain");
        check("t3_emit_count", 32'(emitted.size()), 32'd4);
        for (int k = 0; k < emitted.size(); k++) begin
            check("t3_emit_order", 32'(emitted[k]), 32'h2001 + 32'(k));
        end

        // flush with a word offered
        emitted.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h4001 + 16'(k);
            cycle("t4_push");
        end
        in_valid = 1'b0;
        check("t4_occ_before", 32'(a_occ), 32'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h3001;
        #1;
        check("t4_in_ready_flush", 32'(a_in.ready), 32'd0);
        cycle("t4_flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_occ_after", 32'(a_occ), 32'd0);
        check("t4_out_valid_after", 32'(a_out.valid), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle("t4_drain");
        check("t4_nothing_emitted", 32'(emitted.size()), 32'd0);

        // reset asserted mid-cycle
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h5001 + 16'(k);
            cycle("t5_push");
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle("t5_settle");
        check("t5_pre_valid", 32'(a_out.valid), 32'd1);
        check("t5_pre_data", 32'(a_out.data), 32'h5001);
        #2;
        sync_rst_n = 1'b0;
        #1;
        check("t5_mid_valid", 32'(a_out.valid), 32'd1);
        check("t5_mid_occ", 32'(a_occ), 32'd2);
        cycle("t5_rst");
        check("t5_a_valid", 32'(a_out.valid), 32'd0);
        check("t5_a_data", 32'(a_out.data), 32'h0000);
        check("t5_a_occ", 32'(a_occ), 32'd0);
        check("t5_b_valid", 32'(b_out.valid), 32'd0);
        check("t5_b_data_held", 32'(b_out.data), 32'h5001);
        sync_rst_n = 1'b1;
        cycle("t5_release");

        // full pipe streaming through
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h6001 + 16'(k);
            cycle("t6_fill");
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 16'h6004 + 16'(k);
            cycle("t6_stream");
            check("t6_occ", 32'(a_occ), 32'd3);
            check("t6_in_ready", 32'(a_in.ready), 32'd1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) cycle("t6_drain");

        // random traffic with occasional flush and reset
        for (int k = 0; k < 400; k++) begin
            in_valid   = ($urandom % 4) != 0;
            out_ready  = ($urandom % 3) != 0;
            flush      = ($urandom % 40) == 0;
            sync_rst_n = ($urandom % 80) != 0;
            in_data    = 16'($urandom);
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
